// File: rtl/mem_copy_dma.sv
// Byte-at-a-time block copy engine driving data_mem, with memmove handling of overlapping regions.
// Optional DMA_SUM_EN adds a running 'sum' of the bytes read during a copy.
module mem_copy_dma #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned LW = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_read_select,
  output logic [AW-1:0] mem_write_select,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write_en,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef DMA_SUM_EN
  ,
  output logic [DW-1:0] sum
`endif
);

  localparam int unsigned EW = LW + 1;
  localparam logic [EW-1:0] MEM_WORDS = EW'(2 ** AW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] rd, rd_nxt;
  logic [AW-1:0] wr, wr_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic          dir_down, dir_nxt;

  logic [EW-1:0] src_end;
  logic [EW-1:0] dst_end;
  logic [AW-1:0] last_off;

  // Range check is done one bit wider than the length so an overflowing end address cannot wrap.
  assign src_end  = EW'(src) + EW'(len);
  assign dst_end  = EW'(dst) + EW'(len);
  assign last_off = AW'(len - LW'(1));

`ifdef DMA_SUM_EN
  logic [DW-1:0] sum_nxt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      dir_down <= 1'b0;
`ifdef DMA_SUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      rd       <= rd_nxt;
      wr       <= wr_nxt;
      cnt      <= cnt_nxt;
      dir_down <= dir_nxt;
`ifdef DMA_SUM_EN
      sum      <= sum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt        = state;
    rd_nxt           = rd;
    wr_nxt           = wr;
    cnt_nxt          = cnt;
    dir_nxt          = dir_down;
`ifdef DMA_SUM_EN
    sum_nxt          = sum;
`endif
    mem_read_select  = '0;
    mem_write_select = '0;
    mem_wdata        = '0;
    mem_write_en     = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    err              = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if ((src_end > MEM_WORDS) || (dst_end > MEM_WORDS)) begin
            state_nxt = ST_ERR;
          end else if (len == '0) begin
            state_nxt = ST_DONE;
`ifdef DMA_SUM_EN
            sum_nxt   = '0;
`endif
          end else begin
            cnt_nxt   = len;
            state_nxt = ST_COPY;
`ifdef DMA_SUM_EN
            sum_nxt   = '0;
`endif
            // Copying top-down when the destination is above the source keeps unread bytes intact.
            if (dst > src) begin
              dir_nxt = 1'b1;
              rd_nxt  = src + last_off;
              wr_nxt  = dst + last_off;
            end else begin
              dir_nxt = 1'b0;
              rd_nxt  = src;
              wr_nxt  = dst;
            end
          end
        end
      end
      ST_COPY: begin
        mem_read_select  = rd;
        mem_write_select = wr;
        mem_wdata        = mem_rdata;
        mem_write_en     = 1'b1;
        busy             = 1'b1;
        cnt_nxt          = cnt - LW'(1);
        rd_nxt           = dir_down ? (rd - AW'(1)) : (rd + AW'(1));
        wr_nxt           = dir_down ? (wr - AW'(1)) : (wr + AW'(1));
`ifdef DMA_SUM_EN
        sum_nxt          = sum + mem_rdata;
`endif
        if (cnt == LW'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: attached data_mem, a queue-based memmove model and directed jobs.
// Build with DMA_SUM_EN defined to also check the optional sum output.
module tb_mem_copy_dma;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [3:0] src;
  logic [3:0] dst;
  logic [4:0] len;
  logic [7:0] mem_rdata;
  logic [3:0] mem_read_select;
  logic [3:0] mem_write_select;
  logic [7:0] mem_wdata;
  logic       mem_write_en;
  logic       busy;
  logic       done;
  logic       err;
`ifdef DMA_SUM_EN
  logic [7:0] sum;
`endif

  mem_copy_dma #(.AW(4), .DW(8), .LW(5)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .src              (src),
    .dst              (dst),
    .len              (len),
    .mem_rdata        (mem_rdata),
    .mem_read_select  (mem_read_select),
    .mem_write_select (mem_write_select),
    .mem_wdata        (mem_wdata),
    .mem_write_en     (mem_write_en),
    .busy             (busy),
    .done             (done),
    .err              (err)
`ifdef DMA_SUM_EN
    ,
    .sum              (sum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] init_byte(int i);
    case (i)
      0: return 8'd7;   1: return 8'd3;  2: return 8'd2;   3: return 8'd1;
      4: return 8'd6;   5: return 8'd4;  6: return 8'd5;   7: return 8'd8;
      8: return 8'd25;  9: return 8'd8;
      default: return 8'd0;
    endcase
  endfunction

  // data_mem: combinational read, posedge write, bench-controlled preload
  logic [7:0] mem [16];
  logic       preload_req;
  assign mem_rdata = mem[mem_read_select];

  always @(posedge clock) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_byte(i);
    end else if (mem_write_en) begin
      mem[mem_write_select] <= mem_wdata;
    end
  end

  // Expected per-cycle outputs: {busy, write_en, done, err, read_sel, write_sel, wdata}
  typedef struct packed {
    logic       busy;
    logic       we;
    logic       done;
    logic       err;
    logic [3:0] rs;
    logic [3:0] ws;
    logic [7:0] wd;
  } exp_t;

  exp_t       q[$];
  exp_t       cur = '0;
  logic       cur_idle = 1'b1;
  logic [7:0] ref_mem [16];
  logic [7:0] m_sum = 8'd0;

  // Behavioural model: an accepted request expands into its full list of cycle records at once.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      cur      = '0;
      cur_idle = 1'b1;
      m_sum    = 8'd0;
    end else begin
      if (preload_req) begin
        for (int i = 0; i < 16; i++) ref_mem[i] = init_byte(i);
      end
      if (cur.we) begin
        ref_mem[cur.ws] = cur.wd;
        m_sum = m_sum + cur.wd;
      end
      if (cur_idle && start) begin
        int s;
        int d;
        int n;
        logic [7:0] snap [16];
        exp_t e;
        s = int'(src);
        d = int'(dst);
        n = int'(len);
        if ((s + n > 16) || (d + n > 16)) begin
          e = '0; e.err = 1'b1; q.push_back(e);
        end else begin
          m_sum = 8'd0;
          for (int i = 0; i < n; i++) snap[i] = ref_mem[s + i];
          for (int k = 0; k < n; k++) begin
            int j;
            j = (d > s) ? (n - 1 - k) : k;
            e = '0;
            e.busy = 1'b1;
            e.we   = 1'b1;
            e.rs   = 4'(s + j);
            e.ws   = 4'(d + j);
            e.wd   = snap[j];
            q.push_back(e);
          end
          e = '0; e.done = 1'b1; q.push_back(e);
        end
      end
      if (q.size() > 0) begin
        cur      = q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur      = '0;
        cur_idle = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int last_done_cyc = -1;
  int last_err_cyc = -1;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clock);
      cyc++;
      if (chk_en) begin
        check("cycle_outputs",
              32'({busy, mem_write_en, done, err, mem_read_select, mem_write_select, mem_wdata}),
              32'(cur));
`ifdef DMA_SUM_EN
        check("cycle_sum", 32'(sum), 32'(m_sum));
`endif
      end
      if (mem_write_en) we_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (err) begin err_cnt++; last_err_cyc = cyc; end
    end
  endtask

  task automatic preload();
    @(posedge clock); #2 preload_req = 1'b1;
    @(posedge clock); #2 preload_req = 1'b0;
  endtask

  // Raises start for exactly one edge (T0); returns just after T0 with the checker cycle index at T0.
  task automatic start_pulse(input int s, input int d, input int n, output int c0);
    @(posedge clock); #2;
    src = 4'(s); dst = 4'(d); len = 5'(n); start = 1'b1;
    @(posedge clock);
    c0 = cyc;
    #2 start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic expect_bytes(input string tag, input int base, input int n, input logic [63:0] vals);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_mem%0d", tag, base + i), 32'(mem[base + i]), 32'(vals[8*(n-1-i) +: 8]));
  endtask

  task automatic check_mem_vs_model(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_model_mem%0d", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic run_tests();
    int c0;
    int c_dummy;
    int we0;
    int done0;
    int err0;
    int busy0;

    // reset state
    wait_cycles(2);
    chk_en = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_en", 32'(mem_write_en), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_selects", 32'({mem_read_select, mem_write_select, mem_wdata}), 32'd0);
    @(posedge clock); #2 reset_n = 1'b1;

    // 1: non-overlapping copy
    preload();
    we0 = we_cnt;
    start_pulse(0, 10, 4, c0);
    wait_cycles(7);
    expect_bytes("t1", 10, 4, {8'd7, 8'd3, 8'd2, 8'd1});
    check("t1_writes", 32'(we_cnt - we0), 32'd4);
    check("t1_done_cycle", 32'(last_done_cyc - c0), 32'd5);
`ifdef DMA_SUM_EN
    check("t1_sum", 32'(sum), 32'h0D);
`endif
    check_mem_vs_model("t1");

    // 2: overlap with dst above src
    preload();
    start_pulse(0, 2, 4, c0);
    wait_cycles(7);
    expect_bytes("t2", 0, 6, {8'd7, 8'd3, 8'd7, 8'd3, 8'd2, 8'd1});
    check_mem_vs_model("t2");

    // 3: overlap with dst below src
    preload();
    start_pulse(2, 0, 4, c0);
    wait_cycles(7);
    expect_bytes("t3", 0, 4, {8'd2, 8'd1, 8'd6, 8'd4});
    check_mem_vs_model("t3");

    // 4a: source range past the top of memory is rejected
    preload();
    we0 = we_cnt; err0 = err_cnt; busy0 = busy_cnt;
    start_pulse(14, 0, 3, c0);
    wait_cycles(4);
    check("t4_err_cycle", 32'(last_err_cyc - c0), 32'd1);
    check("t4_err_pulses", 32'(err_cnt - err0), 32'd1);
    check("t4_no_writes", 32'(we_cnt - we0), 32'd0);
    check("t4_no_busy", 32'(busy_cnt - busy0), 32'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("t4_unchanged%0d", i), 32'(mem[i]), 32'(init_byte(i)));

    // 4b: zero length completes at once
    we0 = we_cnt; done0 = done_cnt;
    start_pulse(3, 5, 0, c0);
    wait_cycles(3);
    check("t4_len0_done_cycle", 32'(last_done_cyc - c0), 32'd1);
    check("t4_len0_done_pulses", 32'(done_cnt - done0), 32'd1);
    check("t4_len0_no_writes", 32'(we_cnt - we0), 32'd0);

    // 4c: range ending exactly at the top of memory is accepted
    start_pulse(8, 12, 4, c0);
    wait_cycles(7);
    expect_bytes("t4_edge", 12, 4, {8'd25, 8'd8, 8'd0, 8'd0});
    check_mem_vs_model("t4_edge");

    // 5: reset during a descending copy after three writes (mem[15], mem[14], mem[13])
    preload();
    start_pulse(0, 8, 8, c0);
    wait_cycles(3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_write_en_drop", 32'(mem_write_en), 32'd0);
    check("t5_outputs_zero", 32'({busy, done, err, mem_read_select, mem_write_select, mem_wdata}), 32'd0);
    expect_bytes("t5", 8, 8, {8'd25, 8'd8, 8'd0, 8'd0, 8'd0, 8'd4, 8'd5, 8'd8});
    wait_cycles(2);
    #2 reset_n = 1'b1;
    wait_cycles(1);
    check_mem_vs_model("t5");

    // 6: second start while busy is ignored
    preload();
    we0 = we_cnt; done0 = done_cnt;
    start_pulse(0, 8, 5, c0);
    wait_cycles(1);
    start_pulse(1, 2, 3, c_dummy);
    wait_cycles(8);
    check("t6_writes", 32'(we_cnt - we0), 32'd5);
    check("t6_done_pulses", 32'(done_cnt - done0), 32'd1);
    expect_bytes("t6", 8, 5, {8'd7, 8'd3, 8'd2, 8'd1, 8'd6});
    check_mem_vs_model("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    src         = '0;
    dst         = '0;
    len         = '0;
    preload_req = 1'b0;
    fork
      checker_loop();
      run_tests();
    join_any
  end

endmodule
